// File: rtl/switchbox_cfg_pkg.sv
// Shared constants and types for the switch-box configuration loader.
// Side codes, table geometry, frame sync byte, FSM state and error-code enums.
package switchbox_cfg_pkg;

   localparam int NTB   = 5;
   localparam int NLR   = 4;
   localparam int SEL_W = 3;
   localparam int IDX_W = 3;
   localparam int EW    = SEL_W + IDX_W;
   localparam int N     = 2 * NTB + 2 * NLR;
   localparam int TW    = N * EW;

   localparam logic [7:0] SYNC = 8'hA5;

   localparam logic [SEL_W-1:0] SEL_NONE   = 3'd0;
   localparam logic [SEL_W-1:0] SEL_TOP    = 3'd1;
   localparam logic [SEL_W-1:0] SEL_RIGHT  = 3'd2;
   localparam logic [SEL_W-1:0] SEL_BOTTOM = 3'd3;
   localparam logic [SEL_W-1:0] SEL_LEFT   = 3'd4;

   localparam int TOP_BASE   = 0;
   localparam int BOT_BASE   = 5;
   localparam int LEFT_BASE  = 10;
   localparam int RIGHT_BASE = 14;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_ILLEGAL = 2'd2
   } err_code_e;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CSUM    = 2'd2
   } ld_state_e;

endpackage

// File: rtl/switchbox_cfg_entry_check.sv
// Combinational legality check of one routing-select entry {idx, sel}.
// Ports: entry_i (EW-bit entry), legal_o (1 = entry may be committed).
module switchbox_cfg_entry_check #(
   parameter int NTB = 5,
   parameter int NLR = 4
) (
   input  logic [switchbox_cfg_pkg::EW-1:0] entry_i,
   output logic                             legal_o
);

   logic [2:0] sel;
   logic [2:0] idx;

   assign sel = entry_i[2:0];
   assign idx = entry_i[5:3];

   // NONE ignores idx; top/bottom sides have NTB lanes, left/right NLR.
   always_comb begin
      legal_o = 1'b0;
      case (sel)
         switchbox_cfg_pkg::SEL_NONE:   legal_o = 1'b1;
         switchbox_cfg_pkg::SEL_TOP,
         switchbox_cfg_pkg::SEL_BOTTOM: legal_o = (int'(idx) < NTB);
         switchbox_cfg_pkg::SEL_RIGHT,
         switchbox_cfg_pkg::SEL_LEFT:   legal_o = (int'(idx) < NLR);
         default:                       legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/switchbox_cfg_loader.sv
// Serial framed loader for the 3x3 switch-box routing-select table.
// Ports: clk, rst_n, cfg_din/cfg_vld (serial in), cfg_active (table), cfg_done/cfg_err pulses, err_code, busy.
module switchbox_cfg_loader
   import switchbox_cfg_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_din,
   input  logic          cfg_vld,
   output logic [TW-1:0] cfg_active,
   output logic          cfg_done,
   output logic          cfg_err,
   output logic [1:0]    err_code,
   output logic          busy
);

   localparam logic [6:0] CNT_LAST = 7'(TW - 1);
   localparam logic [2:0] BIT_LAST = 3'(EW - 1);

   ld_state_e       state_q, state_d;
   logic [6:0]      win_q;
   logic [6:0]      cnt_q;
   logic [2:0]      ebit_q;
   logic [EW-2:0]   ent_q;
   logic [2:0]      ccnt_q;
   logic [EW-2:0]   rx_q;
   logic [EW-1:0]   xor_q;
   logic            ill_q;
   logic [TW-1:0]   shadow_q;
   logic [TW-1:0]   active_q;
   logic            done_q;
   logic            err_q;
   err_code_e       code_q;

   logic [7:0]      win_nxt;
   logic [EW-1:0]   ent_nxt;
   logic [EW-1:0]   rx_nxt;
   logic            sync_hit;
   logic            ent_end;
   logic            pay_end;
   logic            frame_end;
   logic            ent_legal;
   logic            good;

   // Window/entry/checksum registers hold only the history; the live bit
   // is appended combinationally so decisions land on the consuming edge.
   assign win_nxt   = {win_q, cfg_din};
   assign ent_nxt   = {ent_q, cfg_din};
   assign rx_nxt    = {rx_q, cfg_din};
   assign sync_hit  = (state_q == ST_HUNT) && cfg_vld && (win_nxt == SYNC);
   assign ent_end   = (state_q == ST_PAYLOAD) && cfg_vld && (ebit_q == BIT_LAST);
   assign pay_end   = ent_end && (cnt_q == CNT_LAST);
   assign frame_end = (state_q == ST_CSUM) && cfg_vld && (ccnt_q == BIT_LAST);
   assign good      = !ill_q && (rx_nxt == xor_q);

   switchbox_cfg_entry_check #(
      .NTB (NTB),
      .NLR (NLR)
   ) u_check (
      .entry_i (ent_nxt),
      .legal_o (ent_legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_HUNT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HUNT:    if (sync_hit)  state_d = ST_PAYLOAD;
         ST_PAYLOAD: if (pay_end)   state_d = ST_CSUM;
         ST_CSUM:    if (frame_end) state_d = ST_HUNT;
         default:                   state_d = ST_HUNT;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_HUNT);
      cfg_done   = done_q;
      cfg_err    = err_q;
      err_code   = code_q;
      cfg_active = active_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q    <= '0;
         cnt_q    <= '0;
         ebit_q   <= '0;
         ent_q    <= '0;
         ccnt_q   <= '0;
         rx_q     <= '0;
         xor_q    <= '0;
         ill_q    <= 1'b0;
         shadow_q <= '0;
         active_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
      end else begin
         done_q <= frame_end && good;
         err_q  <= frame_end && !good;
         if (cfg_vld) begin
            unique case (state_q)
               ST_HUNT: begin
                  if (sync_hit) begin
                     win_q  <= '0;
                     cnt_q  <= '0;
                     ebit_q <= '0;
                     ent_q  <= '0;
                     ccnt_q <= '0;
                     rx_q   <= '0;
                     xor_q  <= '0;
                     ill_q  <= 1'b0;
                  end else begin
                     win_q <= win_nxt[6:0];
                  end
               end
               ST_PAYLOAD: begin
                  cnt_q <= cnt_q + 7'd1;
                  ent_q <= ent_nxt[EW-2:0];
                  if (ent_end) begin
                     ebit_q   <= '0;
                     // Entry 0 arrives first and drifts down to bits [EW-1:0].
                     shadow_q <= {ent_nxt, shadow_q[TW-1:EW]};
                     xor_q    <= xor_q ^ ent_nxt;
                     if (!ent_legal) ill_q <= 1'b1;
                  end else begin
                     ebit_q <= ebit_q + 3'd1;
                  end
               end
               ST_CSUM: begin
                  ccnt_q <= ccnt_q + 3'd1;
                  rx_q   <= rx_nxt[EW-2:0];
                  if (frame_end) begin
                     win_q <= '0;
                     if (good) begin
                        active_q <= shadow_q;
                        code_q   <= ERR_NONE;
                     end else if (ill_q) begin
                        code_q <= ERR_ILLEGAL;
                     end else begin
                        code_q <= ERR_CSUM;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Directed bench for the switch-box config loader with a result scoreboard.
// Frames are modelled when sent; the queued outcome is compared at frame end.
module tb_switchbox_cfg_loader;

   logic         clk;
   logic         rst_n;
   logic         cfg_din;
   logic         cfg_vld;
   logic [107:0] cfg_active;
   logic         cfg_done;
   logic         cfg_err;
   logic [1:0]   err_code;
   logic         busy;

   typedef struct {
      logic         done;
      logic         err;
      logic [1:0]   code;
      logic [107:0] active;
   } exp_t;

   exp_t         sbq[$];
   logic [107:0] exp_active;
   int           total;
   int           passed;
   int           failed;

   switchbox_cfg_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_din    (cfg_din),
      .cfg_vld    (cfg_vld),
      .cfg_active (cfg_active),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .err_code   (err_code),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [107:0] obs,
                      input logic [107:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic legal(input logic [5:0] e);
      logic [2:0] s;
      logic [2:0] i;
      s = e[2:0];
      i = e[5:3];
      if (s == 3'd0) return 1'b1;
      if ((s == 3'd1 || s == 3'd3) && i <= 3'd4) return 1'b1;
      if ((s == 3'd2 || s == 3'd4) && i <= 3'd3) return 1'b1;
      return 1'b0;
   endfunction

   task automatic send_bit(input logic b, input bit gaps);
      if (gaps) begin
         int n;
         n = $urandom_range(0, 2);
         repeat (n) @(negedge clk);
      end
      cfg_din = b;
      cfg_vld = 1'b1;
      @(negedge clk);
      cfg_vld = 1'b0;
      cfg_din = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input bit gaps);
      for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
   endtask

   task automatic send_entries(input logic [107:0] tbl, input int nbits,
                               input bit gaps);
      logic [5:0] e;
      int sent;
      sent = 0;
      for (int k = 0; k < 18; k++) begin
         e = tbl[6*k +: 6];
         for (int b = 5; b >= 0; b--) begin
            if (sent < nbits) send_bit(e[b], gaps);
            sent++;
         end
      end
   endtask

   task automatic wait_result(input string tag);
      exp_t e;
      int   k;
      k = 0;
      while (!(cfg_done || cfg_err) && k < 4) begin
         @(negedge clk);
         k++;
      end
      e = sbq.pop_front();
      chk({tag, "_lat"}, 108'(k), 108'd0);
      chk({tag, "_done"}, 108'(cfg_done), 108'(e.done));
      chk({tag, "_err"}, 108'(cfg_err), 108'(e.err));
      chk({tag, "_code"}, 108'(err_code), 108'(e.code));
      chk({tag, "_active"}, cfg_active, e.active);
      chk({tag, "_busy"}, 108'(busy), 108'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, 108'({cfg_done, cfg_err}), 108'd0);
      chk({tag, "_hold"}, 108'(err_code), 108'(e.code));
   endtask

   task automatic send_frame(input string tag, input logic [107:0] tbl,
                             input logic [5:0] csum, input bit garbage,
                             input bit gaps);
      exp_t       e;
      logic [5:0] x;
      logic       ill;
      x   = '0;
      ill = 1'b0;
      for (int k = 0; k < 18; k++) begin
         x = x ^ tbl[6*k +: 6];
         if (!legal(tbl[6*k +: 6])) ill = 1'b1;
      end
      if (!ill && x == csum) begin
         e = '{1'b1, 1'b0, 2'd0, tbl};
         exp_active = tbl;
      end else begin
         e = '{1'b0, 1'b1, ill ? 2'd2 : 2'd1, exp_active};
      end
      sbq.push_back(e);
      if (garbage) begin
         send_byte(8'hFF, gaps);
         chk({tag, "_idle"}, 108'(busy), 108'd0);
      end
      send_byte(8'hA5, gaps);
      chk({tag, "_busy"}, 108'(busy), 108'd1);
      send_entries(tbl, 108, gaps);
      for (int b = 5; b >= 0; b--) send_bit(csum[b], gaps);
      wait_result(tag);
   endtask

   function automatic logic [107:0] rich_table();
      logic [107:0] t;
      t = '0;
      for (int k = 0; k < 5; k++) t[6*k +: 6] = {3'(k % 4), 3'd2};
      for (int k = 5; k < 10; k++) t[6*k +: 6] = {3'd3, 3'd4};
      for (int k = 10; k < 14; k++) t[6*k +: 6] = {3'(k - 10), 3'd1};
      t[6*14 +: 6] = {3'd7, 3'd0};
      t[6*15 +: 6] = {3'd7, 3'd0};
      t[6*16 +: 6] = {3'd4, 3'd3};
      t[6*17 +: 6] = {3'd4, 3'd3};
      return t;
   endfunction

   function automatic logic [5:0] xsum(input logic [107:0] t);
      logic [5:0] x;
      x = '0;
      for (int k = 0; k < 18; k++) x = x ^ t[6*k +: 6];
      return x;
   endfunction

   initial begin
      logic [107:0] t;
      total      = 0;
      passed     = 0;
      failed     = 0;
      exp_active = '0;
      rst_n      = 1'b0;
      cfg_din    = 1'b0;
      cfg_vld    = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_active", cfg_active, 108'd0);
      chk("rst_done", 108'(cfg_done), 108'd0);
      chk("rst_err", 108'(cfg_err), 108'd0);
      chk("rst_busy", 108'(busy), 108'd0);
      chk("rst_code", 108'(err_code), 108'd0);
      rst_n = 1'b1;
      @(negedge clk);

      t = '0;
      t[5:0] = 6'h12;
      send_frame("good", t, 6'h12, 1'b1, 1'b0);
      send_frame("badcsum", t, 6'h13, 1'b0, 1'b0);

      t[6*10 +: 6] = 6'h29;
      send_frame("illidx", t, 6'h12 ^ 6'h29, 1'b0, 1'b0);

      t = '0;
      t[6*3 +: 6] = 6'h07;
      send_frame("illsel", t, 6'h00, 1'b0, 1'b0);

      t = rich_table();
      send_frame("rich", t, xsum(t), 1'b1, 1'b0);

      t = '0;
      t[5:0] = 6'h12;
      send_frame("gappy", t, 6'h12, 1'b1, 1'b1);

      t = rich_table();
      send_byte(8'hA5, 1'b0);
      send_entries(t, 40, 1'b0);
      chk("midrst_busy_pre", 108'(busy), 108'd1);
      rst_n = 1'b0;
      #1;
      exp_active = '0;
      chk("midrst_active", cfg_active, 108'd0);
      chk("midrst_busy", 108'(busy), 108'd0);
      chk("midrst_code", 108'(err_code), 108'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame("postrst", t, xsum(t), 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
